fifo_rd_stream: RTL and testbench

Read-side adapter for the team's synchronous FIFO: drains the FIFO through its `en_rd`/`empty`/`data_out` port and presents the words as a valid/ready stream. A 3-entry prefetch buffer absorbs the FIFO's one-cycle read latency, so the block sustains one word per cycle with no combinational path from `m_ready` to the FIFO read enable. It sits between the FIFO and any downstream consumer that applies backpressure.

---
 rtl/fifo_rd_stream.sv | 72 +++++++
 tb/tb_fifo_rd_stream.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO into a valid/ready stream via a 3-entry prefetch buffer
// Ports: clk, rst (sync, active-high); fifo_empty/fifo_dout in, fifo_rd_en out (FIFO read side);
//        m_valid/m_data out, m_ready in (stream); flush in; busy out;
//        beat_cnt out (16-bit accepted-beat count) only when FIFO_RD_STREAM_CNT_EN is defined.
module fifo_rd_stream #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_rd_en,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  input  logic          flush,
  output logic          busy
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]   beat_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t        r_state;
  logic [1:0]    r_occ, r_wptr, r_rptr;
  logic          r_pending, r_discard;
  logic [DW-1:0] r_buf [3];
  logic          w_push, w_pop;
  logic [1:0]    w_wptr_nx, w_rptr_nx;
  assign w_push     = r_pending && !r_discard && !flush;
  assign w_pop      = m_valid && m_ready;
  assign w_wptr_nx  = (r_wptr == 2'd2) ? 2'd0 : r_wptr + 2'd1;
  assign w_rptr_nx  = (r_rptr == 2'd2) ? 2'd0 : r_rptr + 2'd1;
  // counting the in-flight read keeps the buffer from overflowing without looking at m_ready
  assign fifo_rd_en = !rst && !flush && !fifo_empty && (({1'b0, r_occ} + {2'b0, r_pending}) < 3'd3);
  assign m_valid    = (r_occ != 2'd0) && !r_discard;
  assign m_data     = r_buf[r_rptr];
  assign busy       = (r_occ != 2'd0) || r_pending || r_discard;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_occ     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pending <= 1'b0;
      r_discard <= 1'b0;
      for (int i = 0; i < 3; i++) r_buf[i] <= '0;
    end else begin
      r_pending <= fifo_rd_en;
      if (flush) begin
        r_occ  <= '0;
        r_wptr <= '0;
        r_rptr <= '0;
        if (r_state != FLUSH) r_discard <= r_pending;
      end else begin
        if (w_push) r_buf[r_wptr] <= fifo_dout;
        if (w_push) r_wptr <= w_wptr_nx;
        if (w_pop) r_rptr <= w_rptr_nx;
        r_occ     <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        r_discard <= 1'b0;
      end
      r_state <= flush ? FLUSH :
                 (r_state == FLUSH) ? (r_discard ? FLUSH : IDLE) :
                 (fifo_rd_en || r_pending || r_occ != 2'd0) ? STREAM : IDLE;
    end
  end
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk) r_cnt <= rst ? 16'd0 : r_cnt + {15'd0, w_pop};
  assign beat_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for fifo_rd_stream with a behavioural FIFO model
module tb_fifo_rd_stream;
  logic       clk = 1'b0;
  logic       rst, flush, m_ready, hold_empty;
  logic       fifo_empty, fifo_rd_en, m_valid, busy;
  logic [7:0] fifo_dout, m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] beat_cnt;
`endif
  logic [7:0] fmem [256];
  int         f_wr = 0, f_rd = 0;
  logic [7:0] exp_q [$];
  int         n_total = 0, n_pass = 0, n_beats = 0;
  always #5 clk = ~clk;
  fifo_rd_stream #(.DW(8)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .flush(flush), .busy(busy)
`ifdef FIFO_RD_STREAM_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );
  assign fifo_empty = (f_wr == f_rd) || hold_empty;
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= fmem[f_rd % 256];
      f_rd      <= f_rd + 1;
    end
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      n_beats++;
      if (exp_q.size() == 0) check("unexpected_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
      else check("beat_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [7:0] v, input bit expect_it);
    fmem[f_wr % 256] = v;
    f_wr++;
    if (expect_it) exp_q.push_back(v);
  endtask
  task automatic drain(input string name, input int lim);
    int k = 0;
    while (exp_q.size() != 0 && k < lim) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask
  initial begin
    int cnt;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b1; hold_empty = 1'b0;
    for (int i = 1; i <= 16; i++) load(8'(i), 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_m_data", m_data, 0);
`ifdef FIFO_RD_STREAM_CNT_EN
      check("rst_beat_cnt", beat_cnt, 0);
`endif
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("first_rd_en", fifo_rd_en, 1);
    check("lat_t0_valid", m_valid, 0);
    @(negedge clk);
    check("lat_t1_valid", m_valid, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("stream_no_bubble", m_valid, 1);
    end
    @(negedge clk);
    check("stream_end_valid", m_valid, 0);
    check("stream_end_busy", busy, 0);
    check("stream_drained", exp_q.size(), 0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("stream_beat_cnt", beat_cnt, 16);
`endif
    tick();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) load(8'(i), 1'b1);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(fifo_rd_en);
    end
    check("stall_rd_pulses", cnt, 3);
    check("stall_m_valid", m_valid, 1);
    check("stall_m_data", m_data, 8'h01);
    tick();
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("resume_rd_en", fifo_rd_en, 1);
    drain("stall_drain", 50);
    repeat (3) @(negedge clk);
    check("stall_end_busy", busy, 0);
    tick();
    m_ready = 1'b0;
    for (int i = 8'h21; i <= 8'h26; i++) load(8'(i), i >= 8'h24);
    repeat (3) tick();
    flush = 1'b1;
    @(negedge clk);
    check("flush_rd_en", fifo_rd_en, 0);
    check("flush_pre_valid", m_valid, 1);
    check("flush_pre_data", m_data, 8'h21);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_post_valid", m_valid, 0);
    tick();
    m_ready = 1'b1;
    drain("flush_drain", 50);
    repeat (3) @(negedge clk);
    check("flush_end_busy", busy, 0);
    tick();
    for (int i = 8'h31; i <= 8'h37; i++) load(8'(i), 1'b1);
    begin
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
        m_ready = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
    end
    check("wrap_drain", exp_q.size(), 0);
    m_ready = 1'b1;
    repeat (3) tick();
    load(8'h41, 1'b1);
    @(negedge clk);
    check("empty_rd_en", fifo_rd_en, 1);
    @(negedge clk);
    check("empty_flag", fifo_empty, 1);
    check("empty_busy", busy, 1);
    @(negedge clk);
    check("empty_delivered", m_valid, 1);
    tick();
    hold_empty = 1'b1;
    load(8'h42, 1'b1);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt += int'(fifo_rd_en);
    end
    check("empty_no_reads", cnt, 0);
    tick();
    hold_empty = 1'b0;
    drain("empty_drain", 20);
`ifdef FIFO_RD_STREAM_CNT_EN
    repeat (3) tick();
    check("pre_wrap_beats", n_beats, 36);
    begin
      int i = 0;
      while (i < 65499) begin
        if (f_wr - f_rd < 200) begin
          load(8'(i), 1'b1);
          i++;
        end
        tick();
      end
    end
    drain("cnt_drain", 1000);
    repeat (3) tick();
    check("cnt_ffff", beat_cnt, 16'hFFFF);
    load(8'h55, 1'b1);
    drain("cnt_last_drain", 20);
    repeat (3) tick();
    check("cnt_wrap", beat_cnt, 16'h0000);
`endif
    check("final_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
